// File: rtl/mem_pkg.sv
// mem_pkg: shared op codes, exception codes, access sizes and FSM states for the memory access unit.
package mem_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic [1:0] {EXC_NONE, EXC_ADEL, EXC_ADES, EXC_BUSERR} exc_e;
    typedef enum logic {S_IDLE, S_REQ} state_e;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LWU = 8'hE6;
    localparam logic [7:0] OP_LD  = 8'hE7;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_SD  = 8'hEF;

    typedef struct packed {
        logic  mem;
        logic  load;
        logic  sext;
        size_e size;
    } op_info_t;

    // Double-word ops only exist on a 64-bit datapath; otherwise they fall through as plain ALU ops.
    function automatic op_info_t decode_op(input logic [7:0] op, input logic wide);
        op_info_t d;
        d = '{1'b0, 1'b0, 1'b0, SZ_B};
        case (op)
            OP_LB:  d = '{1'b1, 1'b1, 1'b1, SZ_B};
            OP_LBU: d = '{1'b1, 1'b1, 1'b0, SZ_B};
            OP_LH:  d = '{1'b1, 1'b1, 1'b1, SZ_H};
            OP_LHU: d = '{1'b1, 1'b1, 1'b0, SZ_H};
            OP_LW:  d = '{1'b1, 1'b1, 1'b1, SZ_W};
            OP_LWU: if (wide) d = '{1'b1, 1'b1, 1'b0, SZ_W};
            OP_LD:  if (wide) d = '{1'b1, 1'b1, 1'b0, SZ_D};
            OP_SB:  d = '{1'b1, 1'b0, 1'b0, SZ_B};
            OP_SH:  d = '{1'b1, 1'b0, 1'b0, SZ_H};
            OP_SW:  d = '{1'b1, 1'b0, 1'b0, SZ_W};
            OP_SD:  if (wide) d = '{1'b1, 1'b0, 1'b0, SZ_D};
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input size_e s, input logic [2:0] a);
        return s == SZ_H ? a[0] : s == SZ_W ? |a[1:0] : s == SZ_D ? |a : 1'b0;
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: req/ack data bus between the memory access unit (master) and a bus slave.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   sel;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;
    logic                  ack;
    logic                  err;

    modport master(output req, we, addr, sel, wdata, input rdata, ack, err);
    modport slave(input req, we, addr, sel, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication and load extraction/extension for one access.
module mem_lane_align import mem_pkg::*; #(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int OW     = $clog2(NB)
) (
    input  size_e             size_i,
    input  logic              sext_i,
    input  logic [OW-1:0]     off_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [NB-1:0]     sel_o,
    output logic [DATA_W-1:0] st_rep_o,
    output logic [DATA_W-1:0] ld_data_o
);
    logic [NB-1:0]     mask;
    logic [DATA_W-1:0] sh;

    assign mask = size_i == SZ_B ? NB'(8'h01) : size_i == SZ_H ? NB'(8'h03) :
                  size_i == SZ_W ? NB'(8'h0F) : NB'(8'hFF);
    assign sel_o = mask << off_i;

    assign st_rep_o = size_i == SZ_B ? {NB{st_data_i[7:0]}} :
                      size_i == SZ_H ? {(NB/2){st_data_i[15:0]}} :
                      size_i == SZ_W ? {(NB/4){st_data_i[31:0]}} : st_data_i;

    assign sh = ld_data_i >> {off_i, 3'b000};
    assign ld_data_o = size_i == SZ_B ? (sext_i ? DATA_W'(signed'(sh[7:0])) : DATA_W'(sh[7:0])) :
                       size_i == SZ_H ? (sext_i ? DATA_W'(signed'(sh[15:0])) : DATA_W'(sh[15:0])) :
                       size_i == SZ_W ? (sext_i ? DATA_W'(signed'(sh[31:0])) : DATA_W'(sh[31:0])) : sh;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MEM stage with req/ack bus, precise address/bus exceptions and MEM/WB register.
module mem_access_unit import mem_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    mem_access_unit_if.master bus,
    output logic              stallreq_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              exc_o,
    output logic [1:0]        exc_code_o,
    output logic [ADDR_W-1:0] badaddr_o
);
    localparam int NB    = DATA_W / 8;
    localparam int OW    = $clog2(NB);
    localparam int CNT_W = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;

    typedef struct packed {
        state_e            st;
        size_e             size;
        logic              load;
        logic              sext;
        logic              kill;
        logic [ADDR_W-1:0] addr;
        logic [NB-1:0]     sel;
        logic [DATA_W-1:0] st_data;
        logic [4:0]        wd;
        logic              wreg;
        logic [CNT_W-1:0]  cnt;
        logic [4:0]        out_wd;
        logic              out_wreg;
        logic [DATA_W-1:0] out_data;
        logic              exc;
        exc_e              code;
        logic [ADDR_W-1:0] bad;
    } regs_t;

    regs_t             r_q, r_d;
    op_info_t          info;
    logic              kill, timeout;
    logic [NB-1:0]     sel;
    logic [DATA_W-1:0] rep, ld;

    assign info    = decode_op(aluop_i, DATA_W == 64);
    assign kill    = r_q.kill | flush_i;
    assign timeout = WAIT_MAX != 0 && !bus.ack && r_q.cnt == CNT_W'(WAIT_MAX - 1);

    // Lane logic serves the incoming op while idle and the captured access while requesting.
    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size_i   (r_q.st == S_REQ ? r_q.size : info.size),
        .sext_i   (r_q.sext),
        .off_i    (r_q.st == S_REQ ? r_q.addr[OW-1:0] : mem_addr_i[OW-1:0]),
        .st_data_i(reg2_i),
        .ld_data_i(bus.rdata),
        .sel_o    (sel),
        .st_rep_o (rep),
        .ld_data_o(ld)
    );

    always_comb begin
        r_d          = r_q;
        r_d.out_wd   = '0;
        r_d.out_wreg = 1'b0;
        r_d.out_data = '0;
        r_d.exc      = 1'b0;
        r_d.code     = EXC_NONE;
        r_d.bad      = '0;
        stallreq_o   = 1'b0;
        if (r_q.st == S_IDLE) begin
            if (valid_i && !flush_i) begin
                if (!info.mem) begin
                    r_d.out_wd   = wd_i;
                    r_d.out_wreg = wreg_i;
                    r_d.out_data = wdata_i;
                end else if (misaligned(info.size, mem_addr_i[2:0])) begin
                    r_d.exc  = 1'b1;
                    r_d.code = info.load ? EXC_ADEL : EXC_ADES;
                    r_d.bad  = mem_addr_i;
                end else begin
                    r_d.st      = S_REQ;
                    r_d.size    = info.size;
                    r_d.load    = info.load;
                    r_d.sext    = info.sext;
                    r_d.kill    = 1'b0;
                    r_d.addr    = mem_addr_i;
                    r_d.sel     = sel;
                    r_d.st_data = rep;
                    r_d.wd      = wd_i;
                    r_d.wreg    = wreg_i;
                    r_d.cnt     = '0;
                    stallreq_o  = 1'b1;
                end
            end
        end else begin
            // A timeout releases the stall so the faulting instruction leaves MEM with its exception.
            stallreq_o = !bus.ack && !timeout;
            if (bus.ack || timeout) begin
                r_d.st = S_IDLE;
                if (!kill && (timeout || bus.err)) begin
                    r_d.exc  = 1'b1;
                    r_d.code = EXC_BUSERR;
                    r_d.bad  = r_q.addr;
                end else if (!kill && r_q.load) begin
                    r_d.out_wd   = r_q.wd;
                    r_d.out_wreg = r_q.wreg;
                    r_d.out_data = ld;
                end
            end else begin
                r_d.kill = kill;
                r_d.cnt  = r_q.cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_q <= '0;
        else     r_q <= r_d;
    end

    assign bus.req    = r_q.st == S_REQ;
    assign bus.we     = r_q.st == S_REQ && !r_q.load;
    assign bus.addr   = {r_q.addr[ADDR_W-1:OW], {OW{1'b0}}};
    assign bus.sel    = r_q.sel;
    assign bus.wdata  = r_q.st_data;
    assign wd_o       = r_q.out_wd;
    assign wreg_o     = r_q.out_wreg;
    assign wdata_o    = r_q.out_data;
    assign exc_o      = r_q.exc;
    assign exc_code_o = r_q.code;
    assign badaddr_o  = r_q.bad;
endmodule
